// File: rtl/div_share_arbiter_if.sv
// Bundle of requester and shared-divider signals for div_share_arbiter.
// slave  : arbiter view (takes requests, drives the divider).
// master : environment view (requesters plus divider).
interface div_share_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int CLZ_W = $clog2(DATA_WIDTH);

    // Requester 0
    logic                  r0_start;
    logic [DATA_WIDTH-1:0] r0_dividend;
    logic [CLZ_W-1:0]      r0_dividend_CLZ;
    logic [DATA_WIDTH-1:0] r0_divisor;
    logic [CLZ_W-1:0]      r0_divisor_CLZ;
    logic                  r0_divisor_is_zero;
    logic                  r0_accept;
    logic                  r0_done;
    logic [DATA_WIDTH-1:0] r0_quotient;
    logic [DATA_WIDTH-1:0] r0_remainder;

    // Requester 1
    logic                  r1_start;
    logic [DATA_WIDTH-1:0] r1_dividend;
    logic [CLZ_W-1:0]      r1_dividend_CLZ;
    logic [DATA_WIDTH-1:0] r1_divisor;
    logic [CLZ_W-1:0]      r1_divisor_CLZ;
    logic                  r1_divisor_is_zero;
    logic                  r1_accept;
    logic                  r1_done;
    logic [DATA_WIDTH-1:0] r1_quotient;
    logic [DATA_WIDTH-1:0] r1_remainder;

    // Shared divider
    logic                  div_start;
    logic [DATA_WIDTH-1:0] div_dividend;
    logic [CLZ_W-1:0]      div_dividend_CLZ;
    logic [DATA_WIDTH-1:0] div_divisor;
    logic [CLZ_W-1:0]      div_divisor_CLZ;
    logic                  div_divisor_is_zero;
    logic [DATA_WIDTH-1:0] div_quotient;
    logic [DATA_WIDTH-1:0] div_remainder;
    logic                  div_done;

    modport slave (
        input  r0_start, r0_dividend, r0_dividend_CLZ, r0_divisor, r0_divisor_CLZ, r0_divisor_is_zero,
        output r0_accept, r0_done, r0_quotient, r0_remainder,
        input  r1_start, r1_dividend, r1_dividend_CLZ, r1_divisor, r1_divisor_CLZ, r1_divisor_is_zero,
        output r1_accept, r1_done, r1_quotient, r1_remainder,
        output div_start, div_dividend, div_dividend_CLZ, div_divisor, div_divisor_CLZ, div_divisor_is_zero,
        input  div_quotient, div_remainder, div_done
    );

    modport master (
        output r0_start, r0_dividend, r0_dividend_CLZ, r0_divisor, r0_divisor_CLZ, r0_divisor_is_zero,
        input  r0_accept, r0_done, r0_quotient, r0_remainder,
        output r1_start, r1_dividend, r1_dividend_CLZ, r1_divisor, r1_divisor_CLZ, r1_divisor_is_zero,
        input  r1_accept, r1_done, r1_quotient, r1_remainder,
        input  div_start, div_dividend, div_dividend_CLZ, div_divisor, div_divisor_CLZ, div_divisor_is_zero,
        output div_quotient, div_remainder, div_done
    );
endinterface

// File: rtl/div_share_arbiter.sv
// Two-requester round-robin arbiter in front of one shared unsigned divider.
// One operation in flight at a time; results are held per requester.
// Optional feature: define DIV_ARB_ZERO_BYPASS_EN to answer divide-by-zero
// requests directly (quotient all ones, remainder = dividend) without
// occupying the divider.
module div_share_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    div_share_arbiter_if.slave bus
);
    localparam int CLZ_W = $clog2(DATA_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_owner;
    logic r_ptr;

    logic w_acc0;
    logic w_acc1;
    logic w_any_acc;
    logic w_launch;
    logic w_fin0;
    logic w_fin1;

    logic [DATA_WIDTH-1:0] w_sel_dividend;
    logic [CLZ_W-1:0]      w_sel_dividend_clz;
    logic [DATA_WIDTH-1:0] w_sel_divisor;
    logic [CLZ_W-1:0]      w_sel_divisor_clz;
    logic                  w_sel_zero;

    logic                  r_div_start;
    logic [DATA_WIDTH-1:0] r_div_dividend;
    logic [CLZ_W-1:0]      r_div_dividend_clz;
    logic [DATA_WIDTH-1:0] r_div_divisor;
    logic [CLZ_W-1:0]      r_div_divisor_clz;
    logic                  r_div_divisor_is_zero;

    logic                  r_done0;
    logic                  r_done1;
    logic [DATA_WIDTH-1:0] r_q0;
    logic [DATA_WIDTH-1:0] r_rem0;
    logic [DATA_WIDTH-1:0] r_q1;
    logic [DATA_WIDTH-1:0] r_rem1;

`ifdef DIV_ARB_ZERO_BYPASS_EN
    logic w_byp0;
    logic w_byp1;
`endif

    // Operands of whichever requester is being accepted this cycle
    assign w_any_acc          = w_acc0 | w_acc1;
    assign w_sel_dividend     = w_acc1 ? bus.r1_dividend        : bus.r0_dividend;
    assign w_sel_dividend_clz = w_acc1 ? bus.r1_dividend_CLZ    : bus.r0_dividend_CLZ;
    assign w_sel_divisor      = w_acc1 ? bus.r1_divisor         : bus.r0_divisor;
    assign w_sel_divisor_clz  = w_acc1 ? bus.r1_divisor_CLZ     : bus.r0_divisor_CLZ;
    assign w_sel_zero         = w_acc1 ? bus.r1_divisor_is_zero : bus.r0_divisor_is_zero;

    // Divider completion is only meaningful while an operation is in flight
    assign w_fin0 = (r_state == BUSY) & bus.div_done & ~r_owner;
    assign w_fin1 = (r_state == BUSY) & bus.div_done &  r_owner;

`ifdef DIV_ARB_ZERO_BYPASS_EN
    // Zero-divisor requests are answered locally and never reach the divider
    assign w_byp0   = w_acc0 & bus.r0_divisor_is_zero;
    assign w_byp1   = w_acc1 & bus.r1_divisor_is_zero;
    assign w_launch = w_any_acc & ~w_sel_zero;
`else
    assign w_launch = w_any_acc;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: leave IDLE when the divider is launched, return on div_done
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_launch)     w_state_nxt = BUSY;
            BUSY: if (bus.div_done) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Accept outputs: only in IDLE; on contention the pointer picks the winner
    always_comb begin
        w_acc0 = 1'b0;
        w_acc1 = 1'b0;
        if (r_state == IDLE) begin
            if (bus.r0_start && (!bus.r1_start || !r_ptr)) begin
                w_acc0 = 1'b1;
            end else if (bus.r1_start) begin
                w_acc1 = 1'b1;
            end
        end
    end

    // Owner, round-robin pointer, divider start pulse and done pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= 1'b0;
            r_ptr       <= 1'b0;
            r_div_start <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
        end else begin
            if (w_any_acc) begin
                r_owner <= w_acc1;
                r_ptr   <= w_acc0;
            end
            r_div_start <= w_launch;
`ifdef DIV_ARB_ZERO_BYPASS_EN
            r_done0 <= w_fin0 | w_byp0;
            r_done1 <= w_fin1 | w_byp1;
`else
            r_done0 <= w_fin0;
            r_done1 <= w_fin1;
`endif
        end
    end

    // Divider operand registers, held from launch until the next launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_dividend        <= '0;
            r_div_dividend_clz    <= '0;
            r_div_divisor         <= '0;
            r_div_divisor_clz     <= '0;
            r_div_divisor_is_zero <= 1'b0;
        end else if (w_launch) begin
            r_div_dividend        <= w_sel_dividend;
            r_div_dividend_clz    <= w_sel_dividend_clz;
            r_div_divisor         <= w_sel_divisor;
            r_div_divisor_clz     <= w_sel_divisor_clz;
            r_div_divisor_is_zero <= w_sel_zero;
        end
    end

    // Per-requester result registers; only the owner's pair is ever written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q0   <= '0;
            r_rem0 <= '0;
            r_q1   <= '0;
            r_rem1 <= '0;
        end else begin
            if (w_fin0) begin
                r_q0   <= bus.div_quotient;
                r_rem0 <= bus.div_remainder;
            end
            if (w_fin1) begin
                r_q1   <= bus.div_quotient;
                r_rem1 <= bus.div_remainder;
            end
`ifdef DIV_ARB_ZERO_BYPASS_EN
            if (w_byp0) begin
                r_q0   <= '1;
                r_rem0 <= w_sel_dividend;
            end
            if (w_byp1) begin
                r_q1   <= '1;
                r_rem1 <= w_sel_dividend;
            end
`endif
        end
    end

    assign bus.r0_accept    = w_acc0;
    assign bus.r1_accept    = w_acc1;
    assign bus.r0_done      = r_done0;
    assign bus.r1_done      = r_done1;
    assign bus.r0_quotient  = r_q0;
    assign bus.r0_remainder = r_rem0;
    assign bus.r1_quotient  = r_q1;
    assign bus.r1_remainder = r_rem1;

    assign bus.div_start           = r_div_start;
    assign bus.div_dividend        = r_div_dividend;
    assign bus.div_dividend_CLZ    = r_div_dividend_clz;
    assign bus.div_divisor         = r_div_divisor;
    assign bus.div_divisor_CLZ     = r_div_divisor_clz;
    assign bus.div_divisor_is_zero = r_div_divisor_is_zero;
endmodule

// File: doc/div_share_arbiter.md
DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width; CLZ fields are $clog2(DATA_WIDTH) bits (CLZ_W).
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 rN_start  in  1  requester N (N in {0,1}) request valid; held high until rN_accept.
REQ-005 rN_dividend  in  DATA_WIDTH  requester N dividend.
REQ-006 rN_dividend_CLZ  in  CLZ_W  requester N dividend leading-zero count.
REQ-007 rN_divisor  in  DATA_WIDTH  requester N divisor.
REQ-008 rN_divisor_CLZ  in  CLZ_W  requester N divisor leading-zero count.
REQ-009 rN_divisor_is_zero  in  1  requester N divisor-zero flag.
REQ-010 rN_accept  out  1  combinational; request N taken this cycle.
REQ-011 rN_done  out  1  one-cycle result-valid pulse to requester N.
REQ-012 rN_quotient / rN_remainder  out  DATA_WIDTH each  requester N result, registered.
REQ-013 div_start  out  1  start pulse to shared unsigned divider.
REQ-014 div_dividend, div_dividend_CLZ, div_divisor, div_divisor_CLZ, div_divisor_is_zero  out  as REQ-005..009  registered operands to divider.
REQ-015 div_quotient, div_remainder  in  DATA_WIDTH each; div_done  in  1  divider result and completion pulse.

Function
REQ-016 FSM states SHALL be IDLE and BUSY; one owner register (1 bit) and one round-robin pointer (1 bit).
REQ-017 IDLE with exactly one rN_start high: rN_accept=1 that cycle; operands latched; owner=N; next state BUSY.
REQ-018 IDLE with both starts high: only the requester equal to the pointer is accepted; the other sees accept=0 and holds start.
REQ-019 On every accept the pointer SHALL move to the non-granted requester.
REQ-020 div_start SHALL be high exactly one cycle, the cycle after accept; div_* operands stable from that cycle until div_done.
REQ-021 BUSY: rN_accept=0 for both ports regardless of start.
REQ-022 BUSY and div_done=1: quotient/remainder captured into owner's result registers; owner's rN_done=1 next cycle; state returns to IDLE in that same next cycle.
REQ-023 Latency: accept at T, div_start at T+1, div_done at T+k (k>=1), rN_done at T+k+1; a new accept is permitted in cycle T+k+1.
REQ-024 div_done in IDLE SHALL be ignored (no rN_done, no register change).
REQ-025 rN_quotient/rN_remainder SHALL hold their last value until the next rN_done for that port; the non-owner's results never change.
REQ-026 At most one rN_done high in any cycle.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, pointer 0, owner 0, div_start 0, rN_done 0, all result and div_* operand registers 0.
REQ-028 Reset mid-BUSY aborts the operation; no rN_done issued for it; a late div_done after reset is ignored per REQ-024.

Configuration
REQ-029 Macro DIV_ARB_ZERO_BYPASS_EN defined: an accepted request with divisor_is_zero=1 SHALL NOT pulse div_start; rN_done next cycle with quotient all ones, remainder = dividend; state stays IDLE; pointer updates as REQ-019.
REQ-030 Macro undefined: divide-by-zero requests follow REQ-017..023 unchanged; no bypass logic present.

Verification
REQ-031 r0_start, 100/7, divider k=4 -> r0_accept at T, div_start at T+1 only, r0_done at T+5 with quotient 14, remainder 2; r1 outputs unchanged.
REQ-032 Both starts high in IDLE after reset -> r0 accepted; after r0_done, r1 (still held) accepted next cycle; then both again -> r0 loses, r1 wins is not expected: pointer=0 after r1 grant, r0 accepted.
REQ-033 r1_start during BUSY of r0 -> r1_accept stays 0 until r0_done cycle, then r1_accept=1 in that cycle.
REQ-034 rst_n low two cycles after accept, div_done pulses later -> no rN_done, all outputs 0, state IDLE.
REQ-035 DIV_ARB_ZERO_BYPASS_EN defined, r0 dividend 0x1234, divisor_is_zero=1 -> no div_start, r0_done next cycle, quotient 0xFFFFFFFF, remainder 0x1234; macro undefined -> div_start pulses.
